rfetch_sb_dp: RTL and testbench
===============================

// Module: rfetch_sb_dp
// PURPOSE
//  Register-fetch stage between decode and execute.
//  Multi-read-port register file, x0 hardwired to zero, writeback-to-read bypass, per-register busy
//  scoreboard (RAW/WAW interlock) and one registered valid/ready output slot.
//  Accepts decoded operand specifiers, stalls decode until sources are ready, then presents operand
//  data to execute one cycle later.
// PARAMETERS
//  width_p     32  register data width in bits
//  els_p       32  number of architectural registers (power of 2, >=2); lg_els = $clog2(els_p)
//  rd_ports_p  2   number of source-operand read ports (>=1)
// PORTS
//  clk_i          in   1                    clock, all state updates on posedge
//  rst_ni         in   1                    asynchronous active-low reset
//  dec_v_i        in   1                    decode presents a valid instruction
//  dec_ready_o    out  1                    fetch stage accepts this cycle
//  dec_rs_i       in   rd_ports_p*lg_els    source register indices, port k at [k*lg_els +: lg_els]
//  dec_rs_v_i     in   rd_ports_p           per-port source-used flags; unused ports are never interlocked
//  dec_rd_i       in   lg_els               destination register index
//  dec_rd_w_v_i   in   1                    instruction will write dec_rd_i
//  exe_v_o        out  1                    output slot holds a valid instruction
//  exe_ready_i    in   1                    execute consumes the slot this cycle
//  exe_rs_data_o  out  rd_ports_p*width_p   operand data, port k at [k*width_p +: width_p]
//  exe_rd_o       out  lg_els               destination register index, carried forward
//  exe_rd_w_v_o   out  1                    destination-write flag, carried forward
//  wb_v_i         in   1                    writeback valid
//  wb_rd_i        in   lg_els               writeback register index
//  wb_rd_data_i   in   width_p              writeback data
// BEHAVIOUR
//  Reset (async, rst_ni=0):
//   - All registers := 0; busy[] := 0.
//   - exe_v_o=0; exe_rs_data_o=0; exe_rd_o=0; exe_rd_w_v_o=0.
//   - dec_ready_o=0.
//   - Reset mid-operation discards the slot contents and all pending busy bits.
//  Register file:
//   - Write on posedge when wb_v_i && wb_rd_i!=0.
//   - Writes to x0 are dropped; reads of x0 return 0; busy[0] is never set.
//  Scoreboard:
//   - busy[dec_rd_i] set on accept when dec_rd_w_v_i && dec_rd_i!=0.
//   - busy[wb_rd_i] cleared when wb_v_i.
//   - Same-cycle set and clear of the same index: set wins.
//   - Writeback to a non-busy register still writes the file; busy is unchanged.
//  Bypass:
//   - src_rdy[k] = !dec_rs_v_i[k] || dec_rs_i[k]==0 || !busy[rs_k] || (wb_v_i && wb_rd_i==rs_k).
//   - Operand value = wb_rd_data_i when wb_v_i && wb_rd_i==rs_k && rs_k!=0; otherwise the file read.
//  Interlock:
//   - hazard = any !src_rdy[k] || (dec_rd_w_v_i && dec_rd_i!=0 && busy[dec_rd_i] && !(wb_v_i && wb_rd_i==dec_rd_i)).
//  Handshake:
//   - slot_free = !exe_v_o || exe_ready_i.
//   - dec_ready_o = rst_ni && !hazard && slot_free; it is combinational and does not depend on dec_v_i.
//   - Accept = dec_v_i && dec_ready_o. On accept the slot loads operands, rd and rd_w_v; exe_v_o=1 next cycle.
//   - exe_v_o && exe_ready_i && !accept -> exe_v_o=0 next cycle.
//   - While exe_v_o && !exe_ready_i, all exe_* outputs hold stable.
//  Latency: 1 cycle from accept to exe_v_o. Full throughput of 1/cycle when there are no hazards and
//   exe_ready_i=1.
//  Width: no arithmetic; all indices are lg_els bits and compares are exact.
// TESTING
//  1. Reset: rst_ni=0 mid-stream -> exe_v_o=0 and dec_ready_o=0 immediately; after release, reads of
//     x1..x31 return 0.
//  2. WB then read: wb x5=0xDEADBEEF; next cycle issue rs0=5 -> exe_rs_data_o[31:0]=0xDEADBEEF one
//     cycle after accept.
//  3. RAW interlock: issue rd=7; next issue rs1=7 -> dec_ready_o=0 until wb x7=0x1234.
//     In the wb cycle dec_ready_o=1, and the bypassed operand is 0x1234.
//  4. WAW and x0: issue rd=3, then issue rd=3 -> stall until wb x3.
//     Issue rd=0 followed by rs0=0 -> no stall, and data=0.
//  5. Backpressure: exe_ready_i=0 for 3 cycles with a slot full -> dec_ready_o=0 and exe_* stable.
//     exe_ready_i=1 with a new dec_v_i -> back-to-back transfer with no bubble.
//  6. Same-cycle set/clear: busy x9, wb x9 in the same cycle that a new rd=9 issues -> busy[9] remains 1.

Source files
------------

// File: rtl/rfetch_sb_dp.sv
// Register-fetch stage: multi-port register file with x0 tied to zero,
// writeback-to-read bypass, a per-register busy scoreboard for RAW/WAW
// interlock, and a single registered valid/ready slot toward execute.
module rfetch_sb_dp #(
  parameter int width_p    = 32,
  parameter int els_p      = 32,
  parameter int rd_ports_p = 2,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // decode side
  input  logic                            dec_v_i,
  output logic                            dec_ready_o,
  input  logic [rd_ports_p*lg_els_lp-1:0] dec_rs_i,
  input  logic [rd_ports_p-1:0]           dec_rs_v_i,
  input  logic [lg_els_lp-1:0]            dec_rd_i,
  input  logic                            dec_rd_w_v_i,
  // execute side
  output logic                            exe_v_o,
  input  logic                            exe_ready_i,
  output logic [rd_ports_p*width_p-1:0]   exe_rs_data_o,
  output logic [lg_els_lp-1:0]            exe_rd_o,
  output logic                            exe_rd_w_v_o,
  // writeback
  input  logic                            wb_v_i,
  input  logic [lg_els_lp-1:0]            wb_rd_i,
  input  logic [width_p-1:0]              wb_rd_data_i
);

  localparam logic [lg_els_lp-1:0] x0_idx_lp = {lg_els_lp{1'b0}};

  // architectural state
  logic [els_p-1:0][width_p-1:0]          rf_q;
  logic [els_p-1:0]                       busy_q, busy_d;

  // output slot
  logic                                   exe_v_q, exe_v_d;
  logic [rd_ports_p*width_p-1:0]          exe_data_q, exe_data_d;
  logic [lg_els_lp-1:0]                   exe_rd_q, exe_rd_d;
  logic                                   exe_rd_w_v_q, exe_rd_w_v_d;

  // per-port operand resolution
  logic [rd_ports_p-1:0][lg_els_lp-1:0]   rs_idx_s;
  logic [rd_ports_p-1:0]                  wb_hit_s;
  logic [rd_ports_p-1:0]                  src_rdy_s;
  logic [rd_ports_p*width_p-1:0]          opnd_s;

  // handshake / control
  logic                                   waw_s;
  logic                                   hazard_s;
  logic                                   slot_free_s;
  logic                                   dec_ready_s;
  logic                                   accept_s;
  logic                                   wb_wr_en_s;
  logic                                   rd_set_en_s;

  // Resolve each source port: index slice, bypass hit, readiness and operand value
  always_comb begin
    rs_idx_s  = {(rd_ports_p*lg_els_lp){1'b0}};
    wb_hit_s  = {rd_ports_p{1'b0}};
    src_rdy_s = {rd_ports_p{1'b0}};
    opnd_s    = {(rd_ports_p*width_p){1'b0}};
    for (int k = 0; k < rd_ports_p; k++) begin
      rs_idx_s[k]  = dec_rs_i[k*lg_els_lp +: lg_els_lp];
      wb_hit_s[k]  = wb_v_i && (wb_rd_i == rs_idx_s[k]);
      src_rdy_s[k] = !dec_rs_v_i[k]
                  || (rs_idx_s[k] == x0_idx_lp)
                  || !busy_q[rs_idx_s[k]]
                  || wb_hit_s[k];
      // x0 always reads zero, even when a writeback targets it this cycle
      if (rs_idx_s[k] == x0_idx_lp) begin
        opnd_s[k*width_p +: width_p] = {width_p{1'b0}};
      end else if (wb_hit_s[k]) begin
        opnd_s[k*width_p +: width_p] = wb_rd_data_i;
      end else begin
        opnd_s[k*width_p +: width_p] = rf_q[rs_idx_s[k]];
      end
    end
  end

  // Interlock and handshake decisions; a writeback that frees the destination this cycle lifts WAW
  always_comb begin
    waw_s       = dec_rd_w_v_i
               && (dec_rd_i != x0_idx_lp)
               && busy_q[dec_rd_i]
               && !(wb_v_i && (wb_rd_i == dec_rd_i));
    hazard_s    = !(&src_rdy_s) || waw_s;
    slot_free_s = !exe_v_q || exe_ready_i;
    dec_ready_s = rst_ni && !hazard_s && slot_free_s;
    accept_s    = dec_v_i && dec_ready_s;
    wb_wr_en_s  = wb_v_i && (wb_rd_i != x0_idx_lp);
    rd_set_en_s = accept_s && dec_rd_w_v_i && (dec_rd_i != x0_idx_lp);
  end

  // Scoreboard next state: set on accepted write-dest, clear on writeback, set wins on collision
  always_comb begin
    busy_d    = {els_p{1'b0}};
    busy_d[0] = 1'b0;
    for (int i = 1; i < els_p; i++) begin
      busy_d[i] = (rd_set_en_s && (dec_rd_i == lg_els_lp'(i)))
               || (busy_q[i] && !(wb_v_i && (wb_rd_i == lg_els_lp'(i))));
    end
  end

  // Output slot next state: load on accept, empty on consume, otherwise hold
  always_comb begin
    exe_v_d      = exe_v_q;
    exe_data_d   = exe_data_q;
    exe_rd_d     = exe_rd_q;
    exe_rd_w_v_d = exe_rd_w_v_q;
    if (accept_s) begin
      exe_v_d      = 1'b1;
      exe_data_d   = opnd_s;
      exe_rd_d     = dec_rd_i;
      exe_rd_w_v_d = dec_rd_w_v_i;
    end else if (exe_ready_i) begin
      exe_v_d      = 1'b0;
    end else begin
      exe_v_d      = exe_v_q;
    end
  end

  // Register file storage; writes to x0 are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_q <= {(els_p*width_p){1'b0}};
    end else if (wb_wr_en_s) begin
      rf_q[wb_rd_i] <= wb_rd_data_i;
    end
  end

  // Scoreboard busy bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= {els_p{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Output slot registers; reset discards any in-flight instruction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exe_v_q      <= 1'b0;
      exe_data_q   <= {(rd_ports_p*width_p){1'b0}};
      exe_rd_q     <= x0_idx_lp;
      exe_rd_w_v_q <= 1'b0;
    end else begin
      exe_v_q      <= exe_v_d;
      exe_data_q   <= exe_data_d;
      exe_rd_q     <= exe_rd_d;
      exe_rd_w_v_q <= exe_rd_w_v_d;
    end
  end

  assign dec_ready_o   = dec_ready_s;
  assign exe_v_o       = exe_v_q;
  assign exe_rs_data_o = exe_data_q;
  assign exe_rd_o      = exe_rd_q;
  assign exe_rd_w_v_o  = exe_rd_w_v_q;

endmodule

// File: tb/tb_rfetch_sb_dp.sv
// Directed testbench for rfetch_sb_dp: reset, writeback/read, RAW and WAW
// interlock, x0 handling, backpressure and same-cycle busy set/clear.
module tb_rfetch_sb_dp;

  localparam int W = 32;
  localparam int N = 32;
  localparam int P = 2;
  localparam int L = 5;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           dec_v_i = 1'b0;
  logic           dec_ready_o;
  logic [P*L-1:0] dec_rs_i = '0;
  logic [P-1:0]   dec_rs_v_i = '0;
  logic [L-1:0]   dec_rd_i = '0;
  logic           dec_rd_w_v_i = 1'b0;
  logic           exe_v_o;
  logic           exe_ready_i = 1'b1;
  logic [P*W-1:0] exe_rs_data_o;
  logic [L-1:0]   exe_rd_o;
  logic           exe_rd_w_v_o;
  logic           wb_v_i = 1'b0;
  logic [L-1:0]   wb_rd_i = '0;
  logic [W-1:0]   wb_rd_data_i = '0;

  int cmp_cnt = 0;
  int err_cnt = 0;

  rfetch_sb_dp #(.width_p(W), .els_p(N), .rd_ports_p(P)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .dec_v_i       (dec_v_i),
    .dec_ready_o   (dec_ready_o),
    .dec_rs_i      (dec_rs_i),
    .dec_rs_v_i    (dec_rs_v_i),
    .dec_rd_i      (dec_rd_i),
    .dec_rd_w_v_i  (dec_rd_w_v_i),
    .exe_v_o       (exe_v_o),
    .exe_ready_i   (exe_ready_i),
    .exe_rs_data_o (exe_rs_data_o),
    .exe_rd_o      (exe_rd_o),
    .exe_rd_w_v_o  (exe_rd_w_v_o),
    .wb_v_i        (wb_v_i),
    .wb_rd_i       (wb_rd_i),
    .wb_rd_data_i  (wb_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic idle_in();
    dec_v_i      = 1'b0;
    dec_rs_i     = '0;
    dec_rs_v_i   = '0;
    dec_rd_i     = '0;
    dec_rd_w_v_i = 1'b0;
    wb_v_i       = 1'b0;
    wb_rd_i      = '0;
    wb_rd_data_i = '0;
  endtask

  task automatic test_reset();
    idle_in();
    exe_ready_i = 1'b1;
    step(); step();
    cmp_cnt++; if (dec_ready_o !== 1'b0) begin err_cnt++; $display("FAIL rst_ready: got %b want 0", dec_ready_o); end
    cmp_cnt++; if ({exe_v_o, exe_rd_w_v_o, exe_rd_o, exe_rs_data_o} !== {1'b0, 1'b0, 5'd0, 64'd0}) begin
      err_cnt++; $display("FAIL rst_exe: v=%b wv=%b rd=%0d data=%h want all 0", exe_v_o, exe_rd_w_v_o, exe_rd_o, exe_rs_data_o);
    end
    rst_ni = 1'b1;
    // write x1 and issue rd=4 while holding the slot full
    wb_v_i = 1'b1; wb_rd_i = 5'd1; wb_rd_data_i = 32'hAAAA5555;
    dec_v_i = 1'b1; dec_rd_i = 5'd4; dec_rd_w_v_i = 1'b1;
    exe_ready_i = 1'b0;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL rst_first_ready: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    cmp_cnt++; if ({exe_v_o, exe_rd_o} !== {1'b1, 5'd4}) begin err_cnt++; $display("FAIL rst_pre_slot: v=%b rd=%0d want 1/4", exe_v_o, exe_rd_o); end
    #2 rst_ni = 1'b0;
    #1;
    cmp_cnt++; if (exe_v_o !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_v: got %b want 0", exe_v_o); end
    cmp_cnt++; if (dec_ready_o !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_ready: got %b want 0", dec_ready_o); end
    cmp_cnt++; if ({exe_rd_o, exe_rs_data_o} !== {5'd0, 64'd0}) begin err_cnt++; $display("FAIL rst_mid_data: rd=%0d data=%h want 0", exe_rd_o, exe_rs_data_o); end
    step();
    rst_ni = 1'b1;
    exe_ready_i = 1'b1;
    // every register reads zero; x4's pending busy bit is gone
    for (int i = 1; i < N; i++) begin
      dec_v_i = 1'b1;
      dec_rs_i = {5'(N - i), 5'(i)};
      dec_rs_v_i = 2'b11;
      to_neg();
      cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL rst_read_ready x%0d: got %b want 1", i, dec_ready_o); end
      step();
      cmp_cnt++; if ({exe_v_o, exe_rs_data_o} !== {1'b1, 64'd0}) begin
        err_cnt++; $display("FAIL rst_read_zero x%0d: v=%b data=%h want 1/0", i, exe_v_o, exe_rs_data_o);
      end
    end
    idle_in();
    step();
  endtask

  task automatic test_wb_read();
    idle_in();
    wb_v_i = 1'b1; wb_rd_i = 5'd5; wb_rd_data_i = 32'hDEADBEEF;
    step();
    idle_in();
    dec_v_i = 1'b1; dec_rs_i = {5'd0, 5'd5}; dec_rs_v_i = 2'b01;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL wbrd_ready: got %b want 1", dec_ready_o); end
    step();
    dec_v_i = 1'b0;
    cmp_cnt++; if ({exe_v_o, exe_rs_data_o[31:0]} !== {1'b1, 32'hDEADBEEF}) begin
      err_cnt++; $display("FAIL wbrd_data: v=%b data=%h want 1/deadbeef", exe_v_o, exe_rs_data_o[31:0]);
    end
    // bypass into port 1 from a writeback to a non-busy register
    dec_v_i = 1'b1; dec_rs_i = {5'd6, 5'd5}; dec_rs_v_i = 2'b11;
    wb_v_i = 1'b1; wb_rd_i = 5'd6; wb_rd_data_i = 32'h00000055;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL bypass_ready: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    cmp_cnt++; if (exe_rs_data_o !== 64'h00000055_DEADBEEF) begin err_cnt++; $display("FAIL bypass_data: got %h want 00000055deadbeef", exe_rs_data_o); end
    step();
  endtask

  task automatic test_raw();
    idle_in();
    dec_v_i = 1'b1; dec_rd_i = 5'd7; dec_rd_w_v_i = 1'b1;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL raw_issue_ready: got %b want 1", dec_ready_o); end
    step();
    dec_rd_i = 5'd0; dec_rd_w_v_i = 1'b0;
    dec_rs_i = {5'd7, 5'd0}; dec_rs_v_i = 2'b10;
    for (int j = 0; j < 3; j++) begin
      to_neg();
      cmp_cnt++; if (dec_ready_o !== 1'b0) begin err_cnt++; $display("FAIL raw_stall c%0d: got %b want 0", j, dec_ready_o); end
      step();
    end
    wb_v_i = 1'b1; wb_rd_i = 5'd7; wb_rd_data_i = 32'h00001234;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL raw_wb_ready: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    cmp_cnt++; if ({exe_v_o, exe_rs_data_o[63:32]} !== {1'b1, 32'h00001234}) begin
      err_cnt++; $display("FAIL raw_bypass: v=%b data=%h want 1/00001234", exe_v_o, exe_rs_data_o[63:32]);
    end
    dec_v_i = 1'b1; dec_rs_i = {5'd0, 5'd7}; dec_rs_v_i = 2'b01;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL raw_cleared: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    cmp_cnt++; if (exe_rs_data_o[31:0] !== 32'h00001234) begin err_cnt++; $display("FAIL raw_file: got %h want 00001234", exe_rs_data_o[31:0]); end
    step();
  endtask

  task automatic test_waw_x0();
    idle_in();
    dec_v_i = 1'b1; dec_rd_i = 5'd3; dec_rd_w_v_i = 1'b1;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL waw_first: got %b want 1", dec_ready_o); end
    step();
    cmp_cnt++; if ({exe_rd_o, exe_rd_w_v_o} !== {5'd3, 1'b1}) begin err_cnt++; $display("FAIL waw_carry: rd=%0d wv=%b want 3/1", exe_rd_o, exe_rd_w_v_o); end
    for (int j = 0; j < 2; j++) begin
      to_neg();
      cmp_cnt++; if (dec_ready_o !== 1'b0) begin err_cnt++; $display("FAIL waw_stall c%0d: got %b want 0", j, dec_ready_o); end
      step();
    end
    wb_v_i = 1'b1; wb_rd_i = 5'd3; wb_rd_data_i = 32'h00000033;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL waw_release: got %b want 1", dec_ready_o); end
    step();
    // second writer now owns x3, so a reader must stall
    idle_in();
    dec_v_i = 1'b1; dec_rs_i = {5'd0, 5'd3}; dec_rs_v_i = 2'b01;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b0) begin err_cnt++; $display("FAIL waw_rebusy: got %b want 0", dec_ready_o); end
    step();
    wb_v_i = 1'b1; wb_rd_i = 5'd3; wb_rd_data_i = 32'h00000044;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL waw_read_ready: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    cmp_cnt++; if (exe_rs_data_o[31:0] !== 32'h00000044) begin err_cnt++; $display("FAIL waw_read_data: got %h want 00000044", exe_rs_data_o[31:0]); end
    // x0: writer of rd=0 never sets busy, reader of x0 never stalls and reads zero
    dec_v_i = 1'b1; dec_rd_i = 5'd0; dec_rd_w_v_i = 1'b1;
    step();
    dec_rs_i = {5'd0, 5'd0}; dec_rs_v_i = 2'b11;
    wb_v_i = 1'b1; wb_rd_i = 5'd0; wb_rd_data_i = 32'hFFFFFFFF;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL x0_ready: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    cmp_cnt++; if ({exe_v_o, exe_rs_data_o} !== {1'b1, 64'd0}) begin err_cnt++; $display("FAIL x0_bypass: v=%b data=%h want 1/0", exe_v_o, exe_rs_data_o); end
    dec_v_i = 1'b1; dec_rs_i = {5'd0, 5'd0}; dec_rs_v_i = 2'b11;
    step();
    idle_in();
    cmp_cnt++; if (exe_rs_data_o !== 64'd0) begin err_cnt++; $display("FAIL x0_file: got %h want 0", exe_rs_data_o); end
    step();
  endtask

  task automatic test_back_to_back();
    idle_in();
    exe_ready_i = 1'b0;
    dec_v_i = 1'b1; dec_rs_i = {5'd0, 5'd5}; dec_rs_v_i = 2'b01; dec_rd_i = 5'd10; dec_rd_w_v_i = 1'b1;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL bp_first: got %b want 1", dec_ready_o); end
    step();
    dec_rs_i = {5'd6, 5'd0}; dec_rs_v_i = 2'b10; dec_rd_i = 5'd11; dec_rd_w_v_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      to_neg();
      cmp_cnt++; if (dec_ready_o !== 1'b0) begin err_cnt++; $display("FAIL bp_ready c%0d: got %b want 0", j, dec_ready_o); end
      cmp_cnt++; if ({exe_v_o, exe_rd_o, exe_rd_w_v_o, exe_rs_data_o} !== {1'b1, 5'd10, 1'b1, 64'h00000000_DEADBEEF}) begin
        err_cnt++; $display("FAIL bp_hold c%0d: v=%b rd=%0d wv=%b data=%h want 1/10/1/00000000deadbeef", j, exe_v_o, exe_rd_o, exe_rd_w_v_o, exe_rs_data_o);
      end
      step();
    end
    exe_ready_i = 1'b1;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL bp_release: got %b want 1", dec_ready_o); end
    step();
    cmp_cnt++; if ({exe_v_o, exe_rd_o, exe_rd_w_v_o, exe_rs_data_o} !== {1'b1, 5'd11, 1'b0, 64'h00000055_00000000}) begin
      err_cnt++; $display("FAIL b2b_second: v=%b rd=%0d wv=%b data=%h want 1/11/0/0000005500000000", exe_v_o, exe_rd_o, exe_rd_w_v_o, exe_rs_data_o);
    end
    dec_rs_i = {5'd0, 5'd5}; dec_rs_v_i = 2'b01; dec_rd_i = 5'd12; dec_rd_w_v_i = 1'b0;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    cmp_cnt++; if ({exe_v_o, exe_rd_o, exe_rs_data_o[31:0]} !== {1'b1, 5'd12, 32'hDEADBEEF}) begin
      err_cnt++; $display("FAIL b2b_third: v=%b rd=%0d data=%h want 1/12/deadbeef", exe_v_o, exe_rd_o, exe_rs_data_o[31:0]);
    end
    step();
    cmp_cnt++; if (exe_v_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_drain: got %b want 0", exe_v_o); end
    wb_v_i = 1'b1; wb_rd_i = 5'd10; wb_rd_data_i = 32'h000000A0;
    step();
    idle_in();
  endtask

  task automatic test_same_cycle();
    idle_in();
    dec_v_i = 1'b1; dec_rd_i = 5'd9; dec_rd_w_v_i = 1'b1;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL sc_first: got %b want 1", dec_ready_o); end
    step();
    wb_v_i = 1'b1; wb_rd_i = 5'd9; wb_rd_data_i = 32'h00000099;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL sc_collide_ready: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    dec_v_i = 1'b1; dec_rs_i = {5'd0, 5'd9}; dec_rs_v_i = 2'b01;
    for (int j = 0; j < 2; j++) begin
      to_neg();
      cmp_cnt++; if (dec_ready_o !== 1'b0) begin err_cnt++; $display("FAIL sc_busy_kept c%0d: got %b want 0", j, dec_ready_o); end
      step();
    end
    wb_v_i = 1'b1; wb_rd_i = 5'd9; wb_rd_data_i = 32'h0000009A;
    to_neg();
    cmp_cnt++; if (dec_ready_o !== 1'b1) begin err_cnt++; $display("FAIL sc_release: got %b want 1", dec_ready_o); end
    step();
    idle_in();
    cmp_cnt++; if (exe_rs_data_o[31:0] !== 32'h0000009A) begin err_cnt++; $display("FAIL sc_data: got %h want 0000009a", exe_rs_data_o[31:0]); end
    step();
  endtask

  initial begin
    test_reset();
    test_wb_read();
    test_raw();
    test_waw_x0();
    test_back_to_back();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
